// File: rtl/sll_pkg.sv
// Shared definitions for the RV32I logical-left shifter.
// XLEN is fixed at 32; SHAMT_W is log2(XLEN).
package sll_pkg;
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef logic [XLEN-1:0] word_t;
endpackage : sll_pkg

// File: rtl/sll_stage.sv
// One stage of the log-depth barrel shifter.
// When en is set, the word moves left by DIST and zeros fill the LSBs.
// When en is clear, the word passes through unchanged.
// Each output bit is a 2:1 mux.
module sll_stage
    import sll_pkg::*;
#(
    parameter int DIST = 1
) (
    input  word_t in,
    input  logic  en,
    output word_t out
);

    // Bits pushed past bit XLEN-1 are dropped.
    // The vacated low DIST bits are zero, the same as {in[XLEN-1-DIST:0], zeros}.
    always_comb begin
        out = en ? word_t'(in << DIST) : in;
    end

endmodule : sll_stage

// File: rtl/shift_left_32b.sv
// 32-bit logical left shifter (SLL/SLLI) for the RV32I execute stage.
// The combinational result `out` feeds the ALU mux directly.
// out_q/valid_q is a registered copy for the forwarding/writeback path.
// Optional feature macro: SHIFT_LEFT_32B_PIPE_EN.
// When it is defined, a pipeline register sits after the 16/8/4 stages,
// so out_q/valid_q latency becomes 2 cycles. `out` is unchanged.
//
// Valid semantics: valid_i qualifies in/shamt for the registered path only.
// There is no ready and no backpressure. A sample is taken on every rising edge.
// out_q always updates, whatever valid_i is.
// valid_q is the delayed valid_i, aligned with out_q.
// Consumers must qualify out_q with valid_q.
module shift_left_32b
    import sll_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  word_t              in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               valid_i,
    output word_t              out,
    output word_t              out_q,
    output logic               valid_q
);

    word_t s16;
    word_t s8;
    word_t s4;
    word_t s2;
    word_t s1;

    // Combinational cascade, largest distance first, selected by shamt[4]..shamt[0].
    sll_stage #(.DIST(16)) u_stage16 (.in(in),  .en(shamt[4]), .out(s16));
    sll_stage #(.DIST(8))  u_stage8  (.in(s16), .en(shamt[3]), .out(s8));
    sll_stage #(.DIST(4))  u_stage4  (.in(s8),  .en(shamt[2]), .out(s4));
    sll_stage #(.DIST(2))  u_stage2  (.in(s4),  .en(shamt[1]), .out(s2));
    sll_stage #(.DIST(1))  u_stage1  (.in(s2),  .en(shamt[0]), .out(s1));

    // The zero-latency result. Reset and valid_i have no effect on it.
    always_comb begin
        out = s1;
    end

`ifdef SHIFT_LEFT_32B_PIPE_EN
    word_t      mid_data;
    logic [1:0] mid_shamt;
    logic       mid_valid;
    word_t      tail2;
    word_t      tail1;

    // Mid-pipe register: holds the partial result after the 16/8/4 stages.
    // It also holds the remaining shift bits and the valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mid_data  <= '0;
            mid_shamt <= '0;
            mid_valid <= 1'b0;
        end else begin
            mid_data  <= s4;
            mid_shamt <= shamt[1:0];
            mid_valid <= valid_i;
        end
    end

    // The 2/1 stages are replicated after the register.
    // This keeps the combinational `out` path free of the pipeline.
    sll_stage #(.DIST(2)) u_tail2 (.in(mid_data), .en(mid_shamt[1]), .out(tail2));
    sll_stage #(.DIST(1)) u_tail1 (.in(tail2),    .en(mid_shamt[0]), .out(tail1));

    // Output register: second cycle of the pipelined path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= tail1;
            valid_q <= mid_valid;
        end
    end
`else
    // Output register: captures the combinational result every edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out;
            valid_q <= valid_i;
        end
    end
`endif

endmodule : shift_left_32b

// File: tb/tb_shift_left_32b.sv
// Self-checking bench for shift_left_32b.
// Build with +define+SHIFT_LEFT_32B_PIPE_EN to exercise the 2-cycle pipeline.
module tb_shift_left_32b;

`ifdef SHIFT_LEFT_32B_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [32:0] val;   // {valid, data}
        int          due;   // cycle count at which out_q/valid_q must show it
    } exp_t;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        valid_i;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        valid_q;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    shift_left_32b dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in      (in),
        .shamt   (shamt),
        .valid_i (valid_i),
        .out     (out),
        .out_q   (out_q),
        .valid_q (valid_q)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are applied at the falling edge.
    // `out` is checked 1 ns later.
    // The registered expectation goes to the scoreboard.
    task automatic drive(input logic [31:0] d, input logic [4:0] s, input logic v,
                         input logic [31:0] exp_out, input string name);
        exp_t e;
        @(negedge clk_i);
        in      = d;
        shamt   = s;
        valid_i = v;
        #1;
        check({name, "_comb"}, {1'b0, out}, {1'b0, exp_out});
        e.val = {v, exp_out};
        e.due = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Runs 1 ns after each rising edge.
    // Pops every entry that is due now and compares it with out_q/valid_q.
    always @(posedge clk_i) begin
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("reg_path", {valid_q, out_q}, e.val);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r_in;
        logic [4:0]  r_sh;
        int          wait_cnt;

        rst_i   = 1'b1;
        in      = 32'h0;
        shamt   = 5'd0;
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_state", {valid_q, out_q}, 33'h0);
        rst_i = 1'b0;

        // Directed vectors with hand-computed results.
        drive(32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, "sh31");
        drive(32'hFFFF_FFFF, 5'd4,  1'b1, 32'hFFFF_FFF0, "sh4");
        drive(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, "sh0");
        drive(32'h1234_5678, 5'd16, 1'b1, 32'h5678_0000, "sh16");
        drive(32'h0000_00FF, 5'd8,  1'b1, 32'h0000_FF00, "sh8");
        drive(32'h0000_0003, 5'd1,  1'b0, 32'h0000_0006, "novalid");
        drive(32'hA5A5_A5A5, 5'd31, 1'b1, 32'h8000_0000, "top_bit");
        drive(32'h8000_0001, 5'd1,  1'b1, 32'h0000_0002, "discard");
        drive(32'h0F0F_0F0F, 5'd2,  1'b1, 32'h3C3C_3C3C, "sh2");
        drive(32'h0000_0001, 5'd21, 1'b1, 32'h0020_0000, "sh21");

        // 1000 random pairs, checked against the language shift operator.
        for (int i = 0; i < 1000; i++) begin
            r_in = $urandom;
            r_sh = 5'($urandom_range(0, 31));
            drive(r_in, r_sh, 1'($urandom_range(0, 1)), r_in << r_sh, "rand");
        end

        // Let the scoreboard drain before the reset scenario.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk_i);
            wait_cnt++;
        end
        check("drain_before_reset", {1'b0, 32'(exp_q.size())}, 33'h0);
        exp_q.delete();

        // Asynchronous reset between edges while valid_q is high.
        @(negedge clk_i);
        in      = 32'h0000_0005;
        shamt   = 5'd2;
        valid_i = 1'b1;
        repeat (LAT) @(posedge clk_i);
        #2;
        check("pre_reset_valid", {valid_q, out_q}, {1'b1, 32'h0000_0014});
        rst_i = 1'b1;
        #1;
        check("async_reset", {valid_q, out_q}, 33'h0);
        in = 32'h0000_0101;
        #1;
        check("comb_in_reset", {1'b0, out}, {1'b0, 32'h0000_0404});
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_held", {valid_q, out_q}, 33'h0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        valid_i = 1'b0;

        // After reset, the registered path works again.
        drive(32'h0000_00FF, 5'd8, 1'b1, 32'h0000_FF00, "post_reset");
        drive(32'h0000_0003, 5'd1, 1'b0, 32'h0000_0006, "post_novalid");

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk_i);
            wait_cnt++;
        end
        #2;
        check("final_drain", {1'b0, 32'(exp_q.size())}, 33'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_left_32b
